quad_mem_banked: RTL and testbench

- Parametrised successor to the fixed three-bank quad-cell memory: N banks of T/X/Y/Z field arrays, inferred as block RAM.
- Adds a valid/ready request port, single-field and whole-quad (4-beat burst) reads, and a write-lock for the ROM banks.
- Sits between the uFork CPU core and cell storage. Bank 0..RAM_BANKS-1 are RAM; the remaining banks are ROM, loaded at boot, then locked.

---
 rtl/quad_mem_pkg.sv | 22 ++
 rtl/quad_field_bank.sv | 38 +++
 rtl/quad_mem_banked.sv | 251 +++++++++++++++++++++++++
 tb/tb_quad_mem_banked.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_mem_pkg.sv
// ----------------------------------------------------------------------------
// quad_mem_pkg
// Shared encodings for the banked quad-cell memory:
//   - field select encodings (T/X/Y/Z)
//   - request FSM state encoding
//   - number of beats in a whole-quad burst read
// ----------------------------------------------------------------------------
package quad_mem_pkg;

    localparam logic [1:0] FIELD_T = 2'd0;
    localparam logic [1:0] FIELD_X = 2'd1;
    localparam logic [1:0] FIELD_Y = 2'd2;
    localparam logic [1:0] FIELD_Z = 2'd3;

    localparam int QUAD_BEATS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/quad_field_bank.sv
// ----------------------------------------------------------------------------
// quad_field_bank
// One field array (T, X, Y or Z) of one bank: DEPTH x DATA_SZ synchronous RAM
// with a registered read, intended to map onto a block RAM. A single address
// serves both the write and the read, and the read returns the old contents
// when both happen on the same edge.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_addr   cell address (read and write)
//   i_wdata  write data
//   o_rdata  registered read data (address sampled one cycle earlier)
// ----------------------------------------------------------------------------
module quad_field_bank #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_SZ-1:0] i_addr,
    input  logic [DATA_SZ-1:0] i_wdata,
    output logic [DATA_SZ-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_SZ;

    logic [DATA_SZ-1:0] r_mem [DEPTH];

    // The storage has no reset so that it maps onto block RAM; contents
    // survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/quad_mem_banked.sv
// ----------------------------------------------------------------------------
// quad_mem_banked
// N-bank quad-cell memory (T/X/Y/Z fields per cell) for the uFork core.
// Banks 0..RAM_BANKS-1 are RAM; the remaining banks are ROM which can be
// write-protected with a lock pulse (cleared only by reset). Requests use a
// valid/ready handshake and are either a single-field write, a single-field
// read, or a whole-quad read returned as four beats (fields T,X,Y,Z).
//
// Optional feature (compile-time macro QUAD_MEM_BANKED_ERR_EN):
//   adds i_err_clr / o_err, a sticky error flag set on a dropped write
//   (locked ROM or out-of-range bank) or an out-of-range read.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req/o_ready  request handshake (accepted when both high)
//   i_wr           1 = write, 0 = read
//   i_quad         whole-quad burst read (ignored for writes)
//   i_bank/i_addr  bank select and cell address
//   i_field        field select for single accesses
//   i_data         write data
//   i_lock         pulse: write-protect all ROM banks
//   o_valid/o_field/o_data   read result beat (o_data holds when idle)
//   o_locked       ROM lock status
//   i_err_clr/o_err          (QUAD_MEM_BANKED_ERR_EN only)
// ----------------------------------------------------------------------------
module quad_mem_banked
    import quad_mem_pkg::*;
#(
    parameter int DATA_SZ   = 16,
    parameter int ADDR_SZ   = 8,
    parameter int NUM_BANKS = 3,
    parameter int RAM_BANKS = 1,
    parameter int BANK_SZ   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    output logic               o_ready,
    input  logic               i_wr,
    input  logic               i_quad,
    input  logic [BANK_SZ-1:0] i_bank,
    input  logic [ADDR_SZ-1:0] i_addr,
    input  logic [1:0]         i_field,
    input  logic [DATA_SZ-1:0] i_data,
    input  logic               i_lock,
`ifdef QUAD_MEM_BANKED_ERR_EN
    input  logic               i_err_clr,
    output logic               o_err,
`endif
    output logic               o_valid,
    output logic [1:0]         o_field,
    output logic [DATA_SZ-1:0] o_data,
    output logic               o_locked
);

    localparam int NUM_CELLS = NUM_BANKS * 4;
    localparam logic [1:0] LAST_BEAT = 2'(QUAD_BEATS - 1);

    // ---------------------------------------------------------------- state
    state_t             r_state;
    logic [1:0]         r_beat;
    logic [BANK_SZ-1:0] r_bank;
    logic [ADDR_SZ-1:0] r_addr;
    logic               r_locked;

    // Read pipeline: describes the word the RAMs present this cycle.
    logic               r_p_valid;
    logic [1:0]         r_p_field;
    logic [BANK_SZ-1:0] r_p_bank;
    logic               r_p_oor;
    logic [DATA_SZ-1:0] r_hold;

    // ---------------------------------------------------------------- wires
    logic               w_accept;
    logic [31:0]        w_in_bank_ext;
    logic               w_in_oor;
    logic               w_in_rom;
    logic               w_wr_ok;
    logic               w_rd_en;
    logic [BANK_SZ-1:0] w_rd_bank;
    logic [1:0]         w_rd_field;
    logic [ADDR_SZ-1:0] w_ram_addr;
    logic               w_rd_oor;
    logic [DATA_SZ-1:0] w_sel_data;
    logic [NUM_CELLS-1:0] w_we;
    logic [DATA_SZ-1:0] w_rdata [NUM_CELLS];

    assign o_ready  = (r_state == ST_IDLE);
    assign w_accept = i_req && o_ready;

    assign w_in_bank_ext = 32'(i_bank);
    assign w_in_oor      = (w_in_bank_ext >= 32'(NUM_BANKS));
    assign w_in_rom      = (w_in_bank_ext >= 32'(RAM_BANKS));

    // The lock flag used here is the registered one, so a write arriving
    // together with the lock pulse still lands.
    assign w_wr_ok = w_accept && i_wr && !w_in_oor && !(w_in_rom && r_locked);

    // ------------------------------------------------------- read issue mux
    // During a burst the latched bank/address drive the RAMs and the beat
    // counter selects the field; otherwise the request port drives them
    // directly so a read issues in its accept cycle.
    always_comb begin
        w_rd_en    = 1'b0;
        w_rd_bank  = i_bank;
        w_rd_field = i_field;
        w_ram_addr = i_addr;
        if (r_state == ST_BURST) begin
            w_rd_en    = 1'b1;
            w_rd_bank  = r_bank;
            w_rd_field = r_beat;
            w_ram_addr = r_addr;
        end else if (w_accept && !i_wr) begin
            w_rd_en = 1'b1;
            if (i_quad) begin
                w_rd_field = FIELD_T;
            end
        end
    end

    assign w_rd_oor = (32'(w_rd_bank) >= 32'(NUM_BANKS));

    // ------------------------------------------------------ field RAM array
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            localparam int         CELL_BANK  = gi / 4;
            localparam logic [1:0] CELL_FIELD = 2'(gi % 4);

            assign w_we[gi] = w_wr_ok
                           && (w_in_bank_ext == 32'(CELL_BANK))
                           && (i_field == CELL_FIELD);

            quad_field_bank #(
                .DATA_SZ (DATA_SZ),
                .ADDR_SZ (ADDR_SZ)
            ) u_ram (
                .i_clk   (i_clk),
                .i_we    (w_we[gi]),
                .i_addr  (w_ram_addr),
                .i_wdata (i_data),
                .o_rdata (w_rdata[gi])
            );
        end
    endgenerate

    // --------------------------------------------------------- request FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_beat  <= 2'd0;
            r_bank  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !i_wr && i_quad) begin
                        // Beat 0 issues in the accept cycle; the burst
                        // state covers beats 1..3.
                        r_state <= ST_BURST;
                        r_beat  <= 2'd1;
                        r_bank  <= i_bank;
                        r_addr  <= i_addr;
                    end
                end
                ST_BURST: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == LAST_BEAT) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- ROM lock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_locked <= 1'b0;
        end else if (i_lock) begin
            r_locked <= 1'b1;
        end
    end

    assign o_locked = r_locked;

    // ------------------------------------------------------ read pipeline
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p_valid <= 1'b0;
            r_p_field <= 2'd0;
            r_p_bank  <= '0;
            r_p_oor   <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_p_valid <= w_rd_en;
            if (w_rd_en) begin
                r_p_field <= w_rd_field;
                r_p_bank  <= w_rd_bank;
                r_p_oor   <= w_rd_oor;
            end
            if (r_p_valid) begin
                r_hold <= w_sel_data;
            end
        end
    end

    // Output mux: the select lines are registered alongside the RAM read,
    // so the selected word is available in the cycle after issue.
    always_comb begin
        w_sel_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int f = 0; f < 4; f++) begin
                if ((32'(r_p_bank) == 32'(b)) && (r_p_field == 2'(f))) begin
                    w_sel_data = w_rdata[b*4 + f];
                end
            end
        end
        if (r_p_oor) begin
            w_sel_data = '0;
        end
    end

    assign o_valid = r_p_valid;
    assign o_field = r_p_field;
    assign o_data  = r_p_valid ? w_sel_data : r_hold;

`ifdef QUAD_MEM_BANKED_ERR_EN
    // ------------------------------------------------------- sticky error
    logic w_err_evt;
    logic r_err;

    assign w_err_evt = w_accept && (w_in_oor || (i_wr && w_in_rom && r_locked));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_quad_mem_banked.sv
module tb_quad_mem_banked;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_wr = 1'b0;
    logic        i_quad = 1'b0;
    logic [1:0]  i_bank = 2'd0;
    logic [7:0]  i_addr = 8'd0;
    logic [1:0]  i_field = 2'd0;
    logic [15:0] i_data = 16'd0;
    logic        i_lock = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [1:0]  o_field;
    logic [15:0] o_data;
    logic        o_locked;
`ifdef QUAD_MEM_BANKED_ERR_EN
    logic        i_err_clr = 1'b0;
    logic        o_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    quad_mem_banked dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (i_req),
        .o_ready  (o_ready),
        .i_wr     (i_wr),
        .i_quad   (i_quad),
        .i_bank   (i_bank),
        .i_addr   (i_addr),
        .i_field  (i_field),
        .i_data   (i_data),
        .i_lock   (i_lock),
`ifdef QUAD_MEM_BANKED_ERR_EN
        .i_err_clr(i_err_clr),
        .o_err    (o_err),
`endif
        .o_valid  (o_valid),
        .o_field  (o_field),
        .o_data   (o_data),
        .o_locked (o_locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------ behavioural model
    // Memory contents indexed by bank/field/addr; a burst is modelled as a
    // count of beats still owed, during which the port is busy.
    logic [15:0] mem [4][4][256];
    int          m_busy = 0;
    bit          m_locked = 0;
    logic [1:0]  m_qbank;
    logic [7:0]  m_qaddr;
    bit          e_valid = 0;
    logic [1:0]  e_field = 0;
    logic [15:0] e_data = 0;

    function automatic logic [15:0] mrd(input logic [1:0] b, input logic [1:0] f, input logic [7:0] a);
        if (b >= 2'd3) return 16'h0;
        return mem[b][f][a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_locked = 0;
            e_valid = 0; e_field = 0; e_data = 0;
        end else begin
            e_valid = 0;
            if (m_busy > 0) begin
                e_valid = 1;
                e_field = 2'(4 - m_busy);
                e_data  = mrd(m_qbank, e_field, m_qaddr);
                m_busy--;
            end else if (i_req) begin
                if (i_wr) begin
                    if (i_bank < 2'd3 && !(i_bank >= 2'd1 && m_locked))
                        mem[i_bank][i_field][i_addr] = i_data;
                end else if (i_quad) begin
                    m_qbank = i_bank; m_qaddr = i_addr;
                    e_valid = 1; e_field = 2'd0;
                    e_data  = mrd(i_bank, 2'd0, i_addr);
                    m_busy  = 3;
                end else begin
                    e_valid = 1; e_field = i_field;
                    e_data  = mrd(i_bank, i_field, i_addr);
                end
            end
            if (i_lock) m_locked = 1;
        end
    end

    // ---------------------------------------------------- compare process
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid",  {31'd0, o_valid},  32'd0);
            chk("rst_ready",  {31'd0, o_ready},  32'd1);
            chk("rst_locked", {31'd0, o_locked}, 32'd0);
            chk("rst_data",   {16'd0, o_data},   32'd0);
            chk("rst_field",  {30'd0, o_field},  32'd0);
        end else begin
            chk("m_valid",  {31'd0, o_valid},  {31'd0, e_valid});
            chk("m_ready",  {31'd0, o_ready},  {31'd0, (m_busy == 0)});
            chk("m_locked", {31'd0, o_locked}, {31'd0, m_locked});
            chk("m_field",  {30'd0, o_field},  {30'd0, e_field});
            chk("m_data",   {16'd0, o_data},   {16'd0, e_data});
        end
    end

    // ----------------------------------------------------- driver tasks
    task automatic req(input bit wr, input bit quad, input logic [1:0] bank,
                       input logic [7:0] addr, input logic [1:0] field,
                       input logic [15:0] data, input bit lock);
        int k;
        @(negedge clk);
        i_req = 1; i_wr = wr; i_quad = quad; i_bank = bank;
        i_addr = addr; i_field = field; i_data = data; i_lock = lock;
        k = 0;
        while (!o_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        $display("[TB] req wr=%0d quad=%0d bank=%0d addr=%02h field=%0d data=%04h lock=%0d",
                 wr, quad, bank, addr, field, data, lock);
    endtask

    task automatic check_lit(input string name, input bit ev, input logic [1:0] ef,
                             input logic [15:0] ed, input bit er);
        @(negedge clk);
        i_req = 0; i_lock = 0;
        chk({name, "_valid"}, {31'd0, o_valid}, {31'd0, ev});
        chk({name, "_field"}, {30'd0, o_field}, {30'd0, ef});
        chk({name, "_data"},  {16'd0, o_data},  {16'd0, ed});
        chk({name, "_ready"}, {31'd0, o_ready}, {31'd0, er});
        $display("[TB] check %s valid=%0d field=%0d data=%04h ready=%0d",
                 name, o_valid, o_field, o_data, o_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_req = 0; i_lock = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst = 0;

        // Single write then read
        req(1, 0, 2'd0, 8'h12, 2'd1, 16'hBEEF, 0);
        req(0, 0, 2'd0, 8'h12, 2'd1, 16'h0, 0);
        check_lit("single", 1, 2'd1, 16'hBEEF, 1);
        idle(1);
        chk("hold_data", {16'd0, o_data}, 32'h0000BEEF);

        // Burst read with literal beats
        req(1, 0, 2'd1, 8'h05, 2'd0, 16'h1111, 0);
        req(1, 0, 2'd1, 8'h05, 2'd1, 16'h2222, 0);
        req(1, 0, 2'd1, 8'h05, 2'd2, 16'h3333, 0);
        req(1, 0, 2'd1, 8'h05, 2'd3, 16'h4444, 0);
        req(0, 1, 2'd1, 8'h05, 2'd0, 16'h0, 0);
        check_lit("beat0", 1, 2'd0, 16'h1111, 0);
        check_lit("beat1", 1, 2'd1, 16'h2222, 0);
        check_lit("beat2", 1, 2'd2, 16'h3333, 0);
        check_lit("beat3", 1, 2'd3, 16'h4444, 1);
        idle(1);

        // Burst followed by a held read: accepted on first ready cycle, no gap
        req(0, 1, 2'd1, 8'h05, 2'd0, 16'h0, 0);
        req(0, 0, 2'd0, 8'h12, 2'd1, 16'h0, 0);
        check_lit("nogap", 1, 2'd1, 16'hBEEF, 1);
        idle(1);

        // Lock
        req(1, 0, 2'd1, 8'h00, 2'd0, 16'hAAAA, 0);
        idle(1);
        @(negedge clk); i_lock = 1;
        @(negedge clk); i_lock = 0;
        chk("locked_set", {31'd0, o_locked}, 32'd1);
        req(1, 0, 2'd1, 8'h00, 2'd0, 16'h5555, 0);
        req(0, 0, 2'd1, 8'h00, 2'd0, 16'h0, 0);
        check_lit("rom_locked", 1, 2'd0, 16'hAAAA, 1);
        req(1, 0, 2'd0, 8'h03, 2'd2, 16'h0BAD, 0);
        req(0, 0, 2'd0, 8'h03, 2'd2, 16'h0, 0);
        check_lit("ram_after_lock", 1, 2'd2, 16'h0BAD, 1);
        idle(1);

        // Out-of-range bank
        req(1, 0, 2'd3, 8'h40, 2'd0, 16'h1234, 0);
        req(0, 0, 2'd3, 8'h40, 2'd0, 16'h0, 0);
        check_lit("oor", 1, 2'd0, 16'h0000, 1);
`ifdef QUAD_MEM_BANKED_ERR_EN
        chk("err_set", {31'd0, o_err}, 32'd1);
        idle(2);
        chk("err_sticky", {31'd0, o_err}, 32'd1);
        @(negedge clk); i_err_clr = 1;
        @(negedge clk); i_err_clr = 0;
        chk("err_clr", {31'd0, o_err}, 32'd0);
`endif
        idle(1);

        // Reset in the middle of a burst (during beat 2)
        req(0, 1, 2'd1, 8'h05, 2'd0, 16'h0, 0);
        @(negedge clk); i_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_beat2", {30'd0, o_field}, 32'd2);
        #2 rst = 1;
        #1 chk("rst_async_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        #1 rst = 0;
        chk("post_rst_ready",  {31'd0, o_ready},  32'd1);
        chk("post_rst_locked", {31'd0, o_locked}, 32'd0);
        req(0, 0, 2'd1, 8'h05, 2'd2, 16'h0, 0);
        check_lit("keep_rom", 1, 2'd2, 16'h3333, 1);
        req(0, 0, 2'd0, 8'h12, 2'd1, 16'h0, 0);
        check_lit("keep_ram", 1, 2'd1, 16'hBEEF, 1);

        // Lock and ROM write in the same cycle
        req(1, 0, 2'd2, 8'h07, 2'd3, 16'h7777, 1);
        req(0, 0, 2'd2, 8'h07, 2'd3, 16'h0, 0);
        check_lit("lock_same_cycle", 1, 2'd3, 16'h7777, 1);
        req(1, 0, 2'd2, 8'h07, 2'd3, 16'h8888, 0);
        req(0, 0, 2'd2, 8'h07, 2'd3, 16'h0, 0);
        check_lit("rom_drop", 1, 2'd3, 16'h7777, 1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
